// File: rtl/op0_sched.sv
// op0_sched: round-robin scheduler that shares one multiply-add unit (C = X + Y*X) among four requesters.
// Optional feature macro OP0_SCHED_CNT_EN adds a 16-bit completed-operation counter on output CNT.
module op0_sched (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  REQ,
    input  logic [15:0] XI,
    input  logic [15:0] YI,
    output logic [3:0]  X,
    output logic [3:0]  Y,
    output logic        H,
    input  logic [7:0]  C,
    output logic [3:0]  GNT,
    output logic [3:0]  ACK,
    output logic [7:0]  R,
    output logic        BUSY
`ifdef OP0_SCHED_CNT_EN
    ,
    output logic [15:0] CNT
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_nx_s;
    logic [1:0]  ptr_r;
    logic [3:0]  gnt_r;
    logic [3:0]  ack_r;
    logic [7:0]  r_r;
    logic [3:0]  xop_r;
    logic [3:0]  yop_r;

    logic [6:0]  req_dbl_s;
    logic [3:0]  req_rot_s;
    logic [1:0]  off_s;
    logic [1:0]  winner_s;
    logic [3:0]  win_hot_s;
    logic [3:0]  win_x_s;
    logic [3:0]  win_y_s;
    logic        grant_s;

    assign grant_s = (state_r == IDLE) && (REQ != 4'd0);

    // Round-robin arbiter: rotate REQ so the pointer position sits at bit 0, then take the lowest set bit.
    always_comb begin
        req_dbl_s = {REQ[2:0], REQ};
        req_rot_s = req_dbl_s[ptr_r +: 4];
        if (req_rot_s[0]) begin
            off_s = 2'd0;
        end else if (req_rot_s[1]) begin
            off_s = 2'd1;
        end else if (req_rot_s[2]) begin
            off_s = 2'd2;
        end else begin
            off_s = 2'd3;
        end
        winner_s  = ptr_r + off_s;
        win_hot_s = 4'b0001 << winner_s;
        win_x_s   = XI[{winner_s, 2'b00} +: 4];
        win_y_s   = YI[{winner_s, 2'b00} +: 4];
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            IDLE: begin
                if (grant_s) begin
                    state_nx_s = EXEC;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            EXEC:    state_nx_s = RESP;
            RESP:    state_nx_s = IDLE;
            default: state_nx_s = IDLE;
        endcase
    end

    // Grant, operand latch, pointer, result capture and completion pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_r <= 2'd0;
            gnt_r <= 4'd0;
            ack_r <= 4'd0;
            r_r   <= 8'd0;
            xop_r <= 4'd0;
            yop_r <= 4'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (grant_s) begin
                        gnt_r <= win_hot_s;
                        xop_r <= win_x_s;
                        yop_r <= win_y_s;
                        ptr_r <= winner_s + 2'd1;
                    end
                end
                EXEC: begin
                    r_r   <= C;
                    ack_r <= gnt_r;
                end
                RESP: begin
                    ack_r <= 4'd0;
                    gnt_r <= 4'd0;
                end
                default: begin
                    ack_r <= 4'd0;
                    gnt_r <= 4'd0;
                end
            endcase
        end
    end

    // Shared-unit drive: operands only visible while executing, zero otherwise.
    always_comb begin
        H    = 1'b0;
        X    = 4'd0;
        Y    = 4'd0;
        BUSY = 1'b0;
        case (state_r)
            EXEC: begin
                H    = 1'b1;
                X    = xop_r;
                Y    = yop_r;
                BUSY = 1'b1;
            end
            RESP: begin
                BUSY = 1'b1;
            end
            default: begin
                H    = 1'b0;
                BUSY = 1'b0;
            end
        endcase
    end

    assign GNT = gnt_r;
    assign ACK = ack_r;
    assign R   = r_r;

`ifdef OP0_SCHED_CNT_EN
    logic [15:0] cnt_r;

    // Completed-operation counter, bumps on each RESP->IDLE edge and wraps naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= 16'd0;
        end else if (state_r == RESP) begin
            cnt_r <= cnt_r + 16'd1;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign CNT = cnt_r;
`endif

endmodule

// File: tb/tb_op0_sched.sv
// Scoreboard bench for op0_sched: directed requests push expected operands/results, a monitor checks them.
module tb_op0_sched;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  REQ = 4'd0;
    logic [15:0] XI = 16'd0;
    logic [15:0] YI = 16'd0;
    logic [3:0]  X;
    logic [3:0]  Y;
    logic        H;
    logic [7:0]  C;
    logic [3:0]  GNT;
    logic [3:0]  ACK;
    logic [7:0]  R;
    logic        BUSY;
`ifdef OP0_SCHED_CNT_EN
    logic [15:0] CNT;
`endif

    int checks = 0;
    int errors = 0;
    logic [7:0]  exec_q[$];
    logic [11:0] ack_q[$];
    logic [7:0]  me;
    logic [11:0] ma;
    int          lat;
    int          t_prev;
    int          cyc = 0;

    op0_sched dut (
        .clk(clk), .rst(rst), .REQ(REQ), .XI(XI), .YI(YI),
        .X(X), .Y(Y), .H(H), .C(C), .GNT(GNT), .ACK(ACK), .R(R), .BUSY(BUSY)
`ifdef OP0_SCHED_CNT_EN
        , .CNT(CNT)
`endif
    );

    // shared multiply-add unit model
    assign C = {4'd0, X} + {4'd0, Y} * {4'd0, X};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Monitor: pops expectations whenever the DUT drives the unit or pulses ACK.
    always @(negedge clk) begin
        if (!rst) begin
            if (H) begin
                if (exec_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL exec_unexpected actual X=%0d Y=%0d expected no operation", X, Y);
                end else begin
                    me = exec_q.pop_front();
                    check("exec_x", {12'd0, X}, {12'd0, me[7:4]});
                    check("exec_y", {12'd0, Y}, {12'd0, me[3:0]});
                end
            end else begin
                check("idle_xy", {8'd0, X, Y}, 16'd0);
            end
            if (ACK != 4'd0) begin
                if (ack_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL ack_unexpected actual ACK=%b expected none", ACK);
                end else begin
                    ma = ack_q.pop_front();
                    check("ack", {12'd0, ACK}, {12'd0, ma[11:8]});
                    check("gnt_eq_ack", {12'd0, GNT}, {12'd0, ma[11:8]});
                    check("result", {8'd0, R}, {8'd0, ma[7:0]});
                end
            end
        end
    end

    // Hold requests, dropping each bit once its ACK is seen; lat = negedges until first ACK.
    task automatic serve(input logic [3:0] req, output int first);
        int n;
        n = 0;
        first = 0;
        REQ = req;
        while (REQ != 4'd0 && n < 40) begin
            @(negedge clk);
            n++;
            if (ACK != 4'd0) begin
                if (first == 0) first = n;
                REQ = REQ & ~ACK;
            end
        end
        if (REQ != 4'd0) begin
            checks++;
            errors++;
            $display("FAIL serve_timeout actual REQ=%b expected 0000", REQ);
            REQ = 4'd0;
        end
    endtask

    initial begin
        int seen;
        int n;
        repeat (2) @(negedge clk);
        check("rst_gnt", {12'd0, GNT}, 16'd0);
        check("rst_ack", {12'd0, ACK}, 16'd0);
        check("rst_r", {8'd0, R}, 16'd0);
        check("rst_busy_h", {14'd0, BUSY, H}, 16'd0);
        rst = 1'b0;
        @(negedge clk);

        // single request: 3 + 4*3 = 15
        XI = 16'h0003; YI = 16'h0004;
        exec_q.push_back(8'h34); ack_q.push_back({4'b0001, 8'd15});
        serve(4'b0001, lat);
        check("latency", lat[15:0], 16'd2);
        repeat (2) @(negedge clk);

        // maximum operands: 15 + 15*15 = 240
        XI = 16'hF000; YI = 16'hF000;
        exec_q.push_back(8'hFF); ack_q.push_back({4'b1000, 8'd240});
        serve(4'b1000, lat);
        repeat (2) @(negedge clk);

        // contention from PTR=0: X_i=i+1, Y_i=i+2 -> R = 3, 8, 15, 24
        XI = 16'h4321; YI = 16'h5432;
        exec_q.push_back(8'h12); ack_q.push_back({4'b0001, 8'd3});
        exec_q.push_back(8'h23); ack_q.push_back({4'b0010, 8'd8});
        exec_q.push_back(8'h34); ack_q.push_back({4'b0100, 8'd15});
        exec_q.push_back(8'h45); ack_q.push_back({4'b1000, 8'd24});
        exec_q.push_back(8'h12); ack_q.push_back({4'b0001, 8'd3});
        REQ = 4'b1111;
        seen = 0; n = 0; t_prev = 0;
        while (seen < 5 && n < 60) begin
            @(negedge clk);
            n++;
            if (ACK != 4'd0) begin
                if (seen > 0) check("ack_spacing", 16'(cyc - t_prev), 16'd3);
                t_prev = cyc;
                seen++;
            end
        end
        REQ = 4'd0;
        check("contention_acks", seen[15:0], 16'd5);
        repeat (2) @(negedge clk);

        // pointer wrap: grant 2 moves PTR to 3, so 0 beats 2
        exec_q.push_back(8'h34); ack_q.push_back({4'b0100, 8'd15});
        serve(4'b0100, lat);
        repeat (2) @(negedge clk);
        exec_q.push_back(8'h12); ack_q.push_back({4'b0001, 8'd3});
        exec_q.push_back(8'h34); ack_q.push_back({4'b0100, 8'd15});
        serve(4'b0101, lat);
        repeat (2) @(negedge clk);
`ifdef OP0_SCHED_CNT_EN
        check("cnt_ops", CNT, 16'd10);
`endif

        // reset while executing: no ACK, state cleared, PTR back to 0
        exec_q.push_back(8'h23);
        REQ = 4'b0010;
        @(negedge clk);
        check("exec_busy", {15'd0, BUSY}, 16'd1);
        #1 rst = 1'b1;
        REQ = 4'd0;
        #1;
        check("abort_gnt", {12'd0, GNT}, 16'd0);
        check("abort_ack", {12'd0, ACK}, 16'd0);
        check("abort_r", {8'd0, R}, 16'd0);
        check("abort_busy_h", {14'd0, BUSY, H}, 16'd0);
`ifdef OP0_SCHED_CNT_EN
        check("cnt_rst", CNT, 16'd0);
`endif
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        exec_q.push_back(8'h23); ack_q.push_back({4'b0010, 8'd8});
        exec_q.push_back(8'h45); ack_q.push_back({4'b1000, 8'd24});
        serve(4'b1010, lat);
        repeat (3) @(negedge clk);
`ifdef OP0_SCHED_CNT_EN
        check("cnt_after_rst", CNT, 16'd2);
`endif

        check("exec_q_drained", exec_q.size(), 16'd0);
        check("ack_q_drained", ack_q.size(), 16'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1);
    end

endmodule

// File: doc/op0_sched.md
OP0_SCHED -- requirements
Module: op0_sched

Interface
REQ-001 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-002 rst  input  1  reset, asynchronous, active-high.
REQ-003 REQ  input  4  per-requester request; bit i SHALL be held high with operands stable until ACK[i].
REQ-004 XI  input  16  packed X operands, requester i on XI[4i+3:4i], unsigned.
REQ-005 YI  input  16  packed Y operands, requester i on YI[4i+3:4i], unsigned.
REQ-006 X  output  4  operand X driven to the shared multiply-add unit (C = X + Y*X).
REQ-007 Y  output  4  operand Y driven to the shared unit.
REQ-008 H  output  1  enable to the shared unit, high only in EXEC.
REQ-009 C  input  8  combinational result returned by the shared unit.
REQ-010 GNT  output  4  one-hot grant, registered.
REQ-011 ACK  output  4  one-cycle completion pulse to the granted requester.
REQ-012 R  output  8  registered result, valid while ACK != 0 and held until next capture.
REQ-013 BUSY  output  1  high in EXEC and RESP.

Function
REQ-014 FSM states SHALL be IDLE, EXEC, RESP; no other reachable state.
REQ-015 IDLE: if REQ == 0, stay; else on the edge, register one-hot GNT per round-robin, latch the winner's 4-bit X/Y into internal operand registers, go EXEC.
REQ-016 Round-robin: search starts at pointer PTR (0..3), ascending with wrap 3->0; first set REQ bit wins.
REQ-017 PTR SHALL update to (winner+1) mod 4 on the grant edge; unchanged otherwise.
REQ-018 EXEC: H = 1, X/Y = latched operands; on the edge, R <= C, ACK[winner] <= 1, go RESP.
REQ-019 RESP: ACK high exactly this cycle; on the edge, ACK <= 0, GNT <= 0, go IDLE.
REQ-020 Outside EXEC: H = 0, X = 0, Y = 0.
REQ-021 Latency: request sampled at edge n -> ACK high in cycle after edge n+1; at most one grant per 3 cycles.
REQ-022 REQ changes during EXEC/RESP SHALL NOT affect the operation in flight (operands latched).
REQ-023 A REQ bit still high when IDLE samples is a new request.
REQ-024 Simultaneous requests: exactly one GNT bit; the others wait, no request lost while held.
REQ-025 R width 8 bits; maximum 15 + 15*15 = 240, so no overflow handling.
REQ-026 At most one ACK bit high at any time; ACK bit SHALL equal the granted bit.

Reset
REQ-027 rst high SHALL immediately force state IDLE, GNT = 0, ACK = 0, R = 0, PTR = 0, operand registers = 0, BUSY = 0, H = 0.
REQ-028 Reset during EXEC/RESP SHALL abort the operation with no ACK issued; the requester re-requests.

Configuration
REQ-029 Macro OP0_SCHED_CNT_EN defined: add output CNT (16 bits), reset 0, incremented on every RESP->IDLE edge, wrapping 0xFFFF->0x0000.
REQ-030 Macro OP0_SCHED_CNT_EN undefined: no CNT port, no counter logic; all other behaviour identical.

Verification
REQ-031 Single: REQ=0001, X0=3, Y0=4 -> GNT=0001, H=1 one cycle with X=3/Y=4, ACK=0001 one cycle, R=15.
REQ-032 Max: REQ=1000, X3=15, Y3=15 -> ACK=1000, R=240.
REQ-033 Contention: REQ=1111 held, re-asserted after each ACK -> grant order 0,1,2,3,0; one ACK every 3 cycles.
REQ-034 Pointer: after grant to 2, REQ=0101 -> requester 0 served before 2 (wrap).
REQ-035 Reset in EXEC: rst pulse while BUSY=1 -> no ACK, R=0, GNT=0, next request granted from PTR=0.
REQ-036 With OP0_SCHED_CNT_EN: 5 completed operations -> CNT=5; rst -> CNT=0.
